// File: rtl/pkt_arbiter2_pkg.sv
// Shared packet-header constants and arbiter FSM encoding, reused by other packet-aware blocks.
package pkt_arbiter2_pkg;

    localparam int LEN_LSB_DEF  = 0;
    localparam int LEN_BITS_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } arb_state_e;

    // Two-way round-robin: on a tie the requester that did not win last time goes.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (v0 && v1) begin
            g = last ? 2'b01 : 2'b10;
        end else if (v0) begin
            g = 2'b01;
        end else if (v1) begin
            g = 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/pkt_outreg.sv
// Registered output stage (flit + start-of-packet flag); one cycle latency.
// in_rdy is high when the register is empty or its flit is leaving; holds while out_bp stalls it.
module pkt_outreg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         in_sof,
    input  logic         out_bp,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    output logic         out_sof
);

    logic [W-1:0] dat_q, dat_d;
    logic         vld_q, vld_d;
    logic         sof_q, sof_d;

    always_comb begin
        in_rdy = !vld_q || !out_bp;
        dat_d  = dat_q;
        vld_d  = vld_q;
        sof_d  = sof_q;
        if (in_rdy) begin
            vld_d = in_vld;
            sof_d = in_vld && in_sof;
            if (in_vld) begin
                dat_d = in_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
            sof_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
            sof_q <= sof_d;
        end
    end

    assign out_dat = dat_q;
    assign out_vld = vld_q;
    assign out_sof = sof_q;

endmodule

// File: rtl/pkt_arbiter2.sv
// Packet-level round-robin arbiter of two flit streams onto one port; grant held for a whole packet.
// One cycle latency input to Q, one idle arbitration cycle between packets; D*_BP follows grant and Q_BP.
module pkt_arbiter2
    import pkt_arbiter2_pkg::*;
#(
    parameter int W        = 64,
    parameter int LEN_LSB  = LEN_LSB_DEF,
    parameter int LEN_BITS = LEN_BITS_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] D0,
    input  logic         D0_VALID,
    output logic         D0_BP,
    input  logic [W-1:0] D1,
    input  logic         D1_VALID,
    output logic         D1_BP,
    output logic [W-1:0] Q,
    output logic         Q_VALID,
    input  logic         Q_BP,
    output logic         Q_SOF,
    output logic [1:0]   GRANT,
    output logic         BUSY
);

    arb_state_e          state_q, state_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          grant_q, grant_d;
    logic                ptr_q, ptr_d;

    logic                out_rdy;
    logic                active;
    logic [1:0]          gnt_rdy;
    logic                xfer;
    logic [W-1:0]        sel_dat;
    logic [LEN_BITS-1:0] hdr_len;

    assign active  = (state_q == ST_HEAD) || (state_q == ST_BODY);
    assign gnt_rdy = grant_q & {2{active && out_rdy}};
    assign D0_BP   = !gnt_rdy[0];
    assign D1_BP   = !gnt_rdy[1];
    assign xfer    = (gnt_rdy[0] && D0_VALID) || (gnt_rdy[1] && D1_VALID);
    assign sel_dat = grant_q[1] ? D1 : D0;
    assign hdr_len = sel_dat[LEN_LSB +: LEN_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = rr_pick(D0_VALID, D1_VALID, ptr_q);
                if (grant_d != 2'b00) begin
                    ptr_d   = grant_d[1];
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (xfer) begin
                    cnt_d = hdr_len;
                    if (hdr_len == '0) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    cnt_d = cnt_q - LEN_BITS'(1);
                    if (cnt_q == LEN_BITS'(1)) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= 2'b00;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    pkt_outreg #(.W(W)) u_outreg (
        .clk     (CLK),
        .rst_n   (RST_N),
        .in_vld  (xfer),
        .in_dat  (sel_dat),
        .in_sof  (state_q == ST_HEAD),
        .out_bp  (Q_BP),
        .in_rdy  (out_rdy),
        .out_dat (Q),
        .out_vld (Q_VALID),
        .out_sof (Q_SOF)
    );

    assign GRANT = grant_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: doc/pkt_arbiter2.md
Name: pkt_arbiter2

Overview:
- Packet-level, two-requester round-robin arbiter sharing one 64-bit VALID/BP stream port, e.g. the ICAP port or a router input, between two sources (PCIe channel and PE).
- Grants are held for a whole packet: header flit plus the payload flits given by its length field. Flits from different packets are never interleaved.
- Output is registered; Q_SOF flags each header flit, used downstream for PE_RST-style pulses.

Parameters:
- W, 64, flit width in bits.
- LEN_LSB, 0, bit position of the payload-length field in the header flit.
- LEN_BITS, 16, width of the length field; value = number of payload flits following the header, 0 is legal.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- D0  in  W  requester 0 flit.
- D0_VALID  in  1  requester 0 flit valid.
- D0_BP  out  1  backpressure to requester 0.
- D1  in  W  requester 1 flit.
- D1_VALID  in  1  requester 1 flit valid.
- D1_BP  out  1  backpressure to requester 1.
- Q  out  W  output flit, registered.
- Q_VALID  out  1  output flit valid.
- Q_BP  in  1  backpressure from the consumer.
- Q_SOF  out  1  high with Q_VALID on a header flit.
- GRANT  out  2  one-hot current owner; 00 when idle.
- BUSY  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, RST_N=0) sets:
  - Q=0, Q_VALID=0, Q_SOF=0, GRANT=00, BUSY=0.
  - D0_BP=D1_BP=1.
  - state=IDLE, length counter=0, last-granted pointer=1, so requester 0 wins first.
- Output stage:
  - out_ready = !Q_VALID || !Q_BP.
  - On out_ready, Q/Q_SOF load the transferred flit and Q_VALID <= (input transfer this cycle).
  - If Q_VALID=1 and Q_BP=1, Q, Q_VALID and Q_SOF hold.
- Input transfer on port i: Di_VALID && GRANT[i] && state in {HEAD, BODY} && out_ready.
- Di_BP = !(GRANT[i] && state in {HEAD, BODY} && out_ready). This is combinational from state and Q_BP; it does not depend on Di_VALID.
- FSM, states IDLE, HEAD, BODY:
  - IDLE: if exactly one Di_VALID is high, grant it. If both are high, grant the one that is not the last granted. Set GRANT and the pointer, go to HEAD. No flit moves in IDLE.
  - HEAD: on transfer, Q_SOF=1 on that flit and cnt <= header[LEN_LSB +: LEN_BITS]. If the length is 0, go to IDLE with GRANT=00; else go to BODY.
  - BODY: on each transfer, cnt <= cnt-1. The transfer made while cnt==1 is the last flit: go to IDLE, GRANT=00.
  - Requester VALID dropping mid-packet: stall in place. No timeout, no grant loss.
- Throughput: one flit per cycle within a packet. There is exactly one idle bubble cycle between packets (the IDLE arbitration cycle).
- Latency: an input flit appears on Q one cycle after its transfer.
- Length 0xFFFF is legal: 65536 flits total.
- The counter is LEN_BITS wide and never wraps, since it reloads only in HEAD.
- Non-granted requester: BP=1 for the whole packet, even if its VALID rises mid-packet. It is served next (round-robin).
- A flit held in the output register across IDLE→HEAD is preserved. The new header can load only when out_ready.
- RST_N asserted mid-packet: immediate abort, all state cleared. Upstream sources must be reset together.

Decomposition:
- Shared package: the header length-field constants (LEN_LSB, LEN_BITS defaults) and the FSM state encoding (IDLE=2'd0, HEAD=2'd1, BODY=2'd2). These are reused by other packet-aware blocks such as router ports.
- One natural sub-module: pkt_outreg, the W+1-bit registered output stage with the out_ready logic. The arbiter FSM stays in pkt_arbiter2.

Test Plan:
- Single packet: D0 sends header len=3 plus 3 flits with Q_BP=0.
  - Q_VALID high for 4 consecutive cycles starting 2 cycles after D0_VALID rises.
  - Q_SOF only on the first of them.
  - GRANT=01 then 00.
  - D1_BP=1 throughout.
- Simultaneous request after reset: D0 and D1 both valid, each len=1.
  - D0's packet goes first.
  - One bubble cycle, then D1's packet.
  - Next simultaneous request goes to D0 again (alternation verified over 4 packets).
- Zero-length packets: D1 sends 3 headers with len=0 back-to-back.
  - 3 Q_SOF flits, each separated by one idle cycle.
  - GRANT returns to 00 after each.
- Backpressure: Q_BP=1 for 5 cycles mid-packet (len=4).
  - Q and Q_VALID hold.
  - Active Di_BP=1 for the same cycles.
  - No flit lost or duplicated; payload order 1,2,3,4 preserved.
- Interleave guard: D1 asserts VALID during D0's len=8 packet.
  - No D1 flit appears until D0's 8th payload flit has left.
  - Then D1's header appears with Q_SOF=1.
- Reset mid-packet: RST_N low during BODY with cnt=5.
  - Q_VALID, GRANT and BUSY clear asynchronously (before the next CLK edge).
  - After release, a fresh D0 packet arbitrates normally.
